// File: rtl/mem_stage_if.sv
// Bundles the execute-side, data-memory and write-back signals of the memory stage.
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_op;
  logic [15:0] ex_alu_out;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_wr_reg;
  logic        ex_wr_en;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done;

  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;
  logic        wb_wr_en;
  logic        wb_err;

  // Environment view: drives instructions and memory responses.
  modport master (
    output ex_valid, ex_op, ex_alu_out, ex_store_data, ex_wr_reg, ex_wr_en,
    output mem_rdata, mem_done,
    input  ex_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
    input  wb_valid, wb_data, wb_reg, wb_wr_en, wb_err
  );

  // Stage view.
  modport slave (
    input  ex_valid, ex_op, ex_alu_out, ex_store_data, ex_wr_reg, ex_wr_en,
    input  mem_rdata, mem_done,
    output ex_ready, mem_addr, mem_wdata, mem_rd, mem_wr,
    output wb_valid, wb_data, wb_reg, wb_wr_en, wb_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs the LD/ST/STU request/done handshake with data memory
// and emits one write-back record per accepted instruction.
module mem_stage #(
  parameter int         TIMEOUT = 16,
  parameter logic [4:0] OP_ST   = 5'd8,
  parameter logic [4:0] OP_LD   = 5'd9,
  parameter logic [4:0] OP_STU  = 5'd10
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ld_q, ld_d;
  logic        stu_q, stu_d;
  logic [2:0]  reg_q, reg_d;
  logic        wren_q, wren_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        wb_valid_q, wb_valid_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [2:0]  wb_reg_q, wb_reg_d;
  logic        wb_wr_en_q, wb_wr_en_d;
  logic        wb_err_q, wb_err_d;
  logic        is_mem;

  assign is_mem = (bus.ex_op == OP_LD) || (bus.ex_op == OP_ST) || (bus.ex_op == OP_STU);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_q       <= 1'b0;
      stu_q      <= 1'b0;
      reg_q      <= '0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_reg_q   <= '0;
      wb_wr_en_q <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_q       <= ld_d;
      stu_q      <= stu_d;
      reg_q      <= reg_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_reg_q   <= wb_reg_d;
      wb_wr_en_q <= wb_wr_en_d;
      wb_err_q   <= wb_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_d       = ld_q;
    stu_d      = stu_q;
    reg_d      = reg_q;
    wren_d     = wren_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_reg_d   = wb_reg_q;
    wb_wr_en_d = wb_wr_en_q;
    wb_err_d   = wb_err_q;

    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus.ex_alu_out;
            wb_reg_d   = bus.ex_wr_reg;
            wb_wr_en_d = bus.ex_wr_en;
            wb_err_d   = 1'b0;
          end else if (bus.ex_alu_out[0]) begin
            // Misaligned word access faults without touching memory.
            wb_valid_d = 1'b1;
            wb_data_d  = bus.ex_alu_out;
            wb_reg_d   = bus.ex_wr_reg;
            wb_wr_en_d = 1'b0;
            wb_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
            ld_d    = (bus.ex_op == OP_LD);
            stu_d   = (bus.ex_op == OP_STU);
            reg_d   = bus.ex_wr_reg;
            wren_d  = bus.ex_wr_en;
            addr_d  = bus.ex_alu_out;
            wdata_d = bus.ex_store_data;
            rd_d    = (bus.ex_op == OP_LD);
            wr_d    = (bus.ex_op != OP_LD);
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // Completion takes priority over a timeout landing on the same edge.
        if (bus.mem_done) begin
          state_d    = IDLE;
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          wb_valid_d = 1'b1;
          wb_reg_d   = reg_q;
          wb_err_d   = 1'b0;
          wb_data_d  = ld_q ? bus.mem_rdata : addr_q;
          wb_wr_en_d = ld_q ? wren_q : stu_q;
        end else if (cnt_d == TIMEOUT_C) begin
          state_d    = IDLE;
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = addr_q;
          wb_reg_d   = reg_q;
          wb_wr_en_d = 1'b0;
          wb_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ex_ready  = (state_q == IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_reg    = wb_reg_q;
  assign bus.wb_wr_en  = wb_wr_en_q;
  assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;
  int   cycles;

  mem_stage_if bus();

  mem_stage #(
    .TIMEOUT(16),
    .OP_ST(5'd8),
    .OP_LD(5'd9),
    .OP_STU(5'd10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Presents one instruction for exactly one cycle.
  task automatic applyStimulus(input logic [4:0] op, input logic [15:0] alu,
                               input logic [15:0] sdata, input logic [2:0] wreg,
                               input logic wren);
    bus.ex_valid      = 1'b1;
    bus.ex_op         = op;
    bus.ex_alu_out    = alu;
    bus.ex_store_data = sdata;
    bus.ex_wr_reg     = wreg;
    bus.ex_wr_en      = wren;
    tick();
    bus.ex_valid = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    bus.ex_op = '0;
    bus.ex_alu_out = '0;
    bus.ex_store_data = '0;
    bus.ex_wr_reg = '0;
    bus.ex_wr_en = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready", 16'(bus.ex_ready), 16'd1);
    checkOutput("rst_rd", 16'(bus.mem_rd), 16'd0);
    checkOutput("rst_wr", 16'(bus.mem_wr), 16'd0);
    checkOutput("rst_wbv", 16'(bus.wb_valid), 16'd0);
    checkOutput("rst_addr", bus.mem_addr, 16'h0000);
    checkOutput("rst_wbdata", bus.wb_data, 16'h0000);

    // ADD passes straight through with one-cycle latency.
    applyStimulus(5'd0, 16'h1234, 16'h0000, 3'd3, 1'b1);
    checkOutput("add_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("add_data", bus.wb_data, 16'h1234);
    checkOutput("add_reg", 16'(bus.wb_reg), 16'd3);
    checkOutput("add_wren", 16'(bus.wb_wr_en), 16'd1);
    checkOutput("add_err", 16'(bus.wb_err), 16'd0);
    checkOutput("add_rdwr", {15'd0, bus.mem_rd | bus.mem_wr}, 16'd0);
    tick();
    checkOutput("add_wbv_pulse", 16'(bus.wb_valid), 16'd0);
    checkOutput("add_data_hold", bus.wb_data, 16'h1234);

    // LD answered in the third request cycle.
    applyStimulus(5'd9, 16'h0010, 16'h0000, 3'd5, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("ld_rd", 16'(bus.mem_rd), 16'd1);
      checkOutput("ld_ready", 16'(bus.ex_ready), 16'd0);
      checkOutput("ld_addr", bus.mem_addr, 16'h0010);
      checkOutput("ld_wbv_busy", 16'(bus.wb_valid), 16'd0);
      if (i == 3) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'hBEEF;
      end
      tick();
    end
    bus.mem_done = 1'b0;
    checkOutput("ld_rd_drop", 16'(bus.mem_rd), 16'd0);
    checkOutput("ld_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("ld_data", bus.wb_data, 16'hBEEF);
    checkOutput("ld_reg", 16'(bus.wb_reg), 16'd5);
    checkOutput("ld_wren", 16'(bus.wb_wr_en), 16'd1);
    checkOutput("ld_err", 16'(bus.wb_err), 16'd0);
    checkOutput("ld_ready_back", 16'(bus.ex_ready), 16'd1);
    tick();
    checkOutput("ld_wbv_pulse", 16'(bus.wb_valid), 16'd0);

    // STU answered in the second request cycle.
    applyStimulus(5'd10, 16'h0040, 16'h00AA, 3'd2, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      checkOutput("stu_wr", 16'(bus.mem_wr), 16'd1);
      checkOutput("stu_rd", 16'(bus.mem_rd), 16'd0);
      checkOutput("stu_addr", bus.mem_addr, 16'h0040);
      checkOutput("stu_wdata", bus.mem_wdata, 16'h00AA);
      if (i == 2) bus.mem_done = 1'b1;
      tick();
    end
    bus.mem_done = 1'b0;
    checkOutput("stu_wr_drop", 16'(bus.mem_wr), 16'd0);
    checkOutput("stu_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("stu_data", bus.wb_data, 16'h0040);
    checkOutput("stu_reg", 16'(bus.wb_reg), 16'd2);
    checkOutput("stu_wren", 16'(bus.wb_wr_en), 16'd1);

    // Plain ST never enables the register write.
    applyStimulus(5'd8, 16'h0080, 16'h1111, 3'd4, 1'b1);
    checkOutput("st_wr", 16'(bus.mem_wr), 16'd1);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    checkOutput("st_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("st_data", bus.wb_data, 16'h0080);
    checkOutput("st_wren", 16'(bus.wb_wr_en), 16'd0);

    // Misaligned ST faults immediately without a request.
    applyStimulus(5'd8, 16'h0041, 16'h2222, 3'd1, 1'b1);
    checkOutput("mis_wr", 16'(bus.mem_wr), 16'd0);
    checkOutput("mis_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("mis_err", 16'(bus.wb_err), 16'd1);
    checkOutput("mis_wren", 16'(bus.wb_wr_en), 16'd0);
    checkOutput("mis_ready", 16'(bus.ex_ready), 16'd1);
    tick();
    checkOutput("mis_wr_later", 16'(bus.mem_wr), 16'd0);

    // Stray done while idle produces nothing.
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_done = 1'b0;
    checkOutput("idle_done_wbv", 16'(bus.wb_valid), 16'd0);
    checkOutput("idle_done_rd", 16'(bus.mem_rd), 16'd0);

    // Silent memory: request stays up 16 cycles, then times out.
    applyStimulus(5'd9, 16'h0020, 16'h0000, 3'd6, 1'b1);
    cycles = 0;
    while (bus.mem_rd && cycles < 40) begin
      cycles++;
      tick();
    end
    checkOutput("to_cycles", 16'(cycles), 16'd16);
    checkOutput("to_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("to_err", 16'(bus.wb_err), 16'd1);
    checkOutput("to_wren", 16'(bus.wb_wr_en), 16'd0);
    checkOutput("to_ready", 16'(bus.ex_ready), 16'd1);
    applyStimulus(5'd0, 16'h5555, 16'h0000, 3'd1, 1'b1);
    checkOutput("to_add_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("to_add_data", bus.wb_data, 16'h5555);
    checkOutput("to_add_err", 16'(bus.wb_err), 16'd0);

    // Done in the 16th cycle beats the timeout.
    applyStimulus(5'd9, 16'h0022, 16'h0000, 3'd7, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'hCAFE;
      end
      tick();
    end
    bus.mem_done = 1'b0;
    checkOutput("edge_wbv", 16'(bus.wb_valid), 16'd1);
    checkOutput("edge_err", 16'(bus.wb_err), 16'd0);
    checkOutput("edge_data", bus.wb_data, 16'hCAFE);

    // Reset in the second access cycle, then a stray done.
    applyStimulus(5'd9, 16'h0030, 16'h0000, 3'd3, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rrst_rd", 16'(bus.mem_rd), 16'd0);
    checkOutput("rrst_wbv", 16'(bus.wb_valid), 16'd0);
    checkOutput("rrst_data", bus.wb_data, 16'h0000);
    checkOutput("rrst_reg", 16'(bus.wb_reg), 16'd0);
    checkOutput("rrst_wren", 16'(bus.wb_wr_en), 16'd0);
    checkOutput("rrst_err", 16'(bus.wb_err), 16'd0);
    checkOutput("rrst_ready", 16'(bus.ex_ready), 16'd1);
    bus.mem_done = 1'b1;
    bus.mem_rdata = 16'h9999;
    tick();
    bus.mem_done = 1'b0;
    checkOutput("rrst_stray_wbv", 16'(bus.wb_valid), 16'd0);
    tick();
    checkOutput("rrst_stray_wbv2", 16'(bus.wb_valid), 16'd0);
    checkOutput("rrst_stray_data", bus.wb_data, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the 16-bit ALU.
- Consumes the ALU result (effective address or computed value), the store data and the destination register.
- For LD/ST/STU it runs a multi-cycle request/done handshake with the data memory. All other ops pass through unchanged.
- Produces one write-back record per accepted instruction and back-pressures the execute stage while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_done before aborting with error (legal range 2..255)
- OP_ST, 8, ALU op code for store
- OP_LD, 9, ALU op code for load
- OP_STU, 10, ALU op code for store-with-update

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_op  in  5  ALU op code, same encoding as the ALU
- ex_alu_out  in  16  ALU result; the address for memory ops
- ex_store_data  in  16  data to store (ST/STU)
- ex_wr_reg  in  3  destination register
- ex_wr_en  in  1  instruction writes a register
- mem_addr  out  16  data memory address
- mem_wdata  out  16  data memory write data
- mem_rd  out  1  read request, level, held until done
- mem_wr  out  1  write request, level, held until done
- mem_rdata  in  16  read data, valid when mem_done=1
- mem_done  in  1  one-cycle completion pulse
- wb_valid  out  1  one-cycle pulse: write-back record valid
- wb_data  out  16  write-back value
- wb_reg  out  3  write-back register
- wb_wr_en  out  1  register write enable, qualified by wb_valid
- wb_err  out  1  access fault (misaligned or timeout)

Behaviour:
- Reset: state IDLE, timeout counter 0.
  - All registered outputs 0: mem_rd, mem_wr, mem_addr, mem_wdata, wb_*.
  - ex_ready = 1 in the cycle after rst deasserts.
  - Reset mid-access drops the request immediately: no wb_valid for the aborted op, and a later mem_done is ignored.
- FSM states: IDLE, ACCESS.
- ex_ready is combinational: 1 in IDLE, 0 in ACCESS. An instruction is accepted when ex_valid & ex_ready.
- IDLE, accepted non-memory op:
  - Next cycle: wb_valid=1, wb_data=ex_alu_out, wb_reg/wb_wr_en copied, wb_err=0.
  - Stay IDLE. Latency 1; back-to-back acceptance every cycle.
- IDLE, accepted LD/ST/STU with ex_alu_out[0]=1 (misaligned word access):
  - No memory request.
  - Next cycle: wb_valid=1, wb_err=1, wb_wr_en=0.
  - Stay IDLE.
- IDLE, accepted aligned LD/ST/STU:
  - Latch op, address, store data, reg, wr_en.
  - Next cycle enter ACCESS with mem_addr/mem_wdata driven. mem_rd=1 for LD; mem_wr=1 for ST/STU.
  - Counter cleared.
- ACCESS:
  - Address, data and request are held stable; counter increments each cycle.
  - mem_done=1 in cycle D: mem_rd/mem_wr drop at D+1, wb_valid=1 at D+1, state IDLE at D+1.
    - LD: wb_data=mem_rdata captured at D, wb_wr_en=latched wr_en.
    - STU: wb_data=address, wb_wr_en=1.
    - ST: wb_data=address, wb_wr_en=0.
  - Counter reaches TIMEOUT without done: drop request, wb_valid=1, wb_err=1, wb_wr_en=0, return to IDLE.
  - mem_done on the same edge the counter reaches TIMEOUT: done wins, no error.
- mem_done while IDLE is ignored.
- wb_valid is never high two cycles for one instruction. wb_* other than wb_valid hold their last value when wb_valid=0.
- At most one outstanding memory access; ex_valid during ACCESS is not accepted and the upstream holds its inputs.

Test Plan:
- Reset, then ADD with alu_out=0x1234, reg=3, wr_en=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_reg=3, wb_wr_en=1, wb_err=0; mem_rd/mem_wr stay 0.
- LD addr=0x0010, memory returns 0xBEEF with mem_done 3 cycles after mem_rd rises -> mem_rd high exactly 3 cycles, ex_ready=0 throughout, wb_valid one cycle after done with wb_data=0xBEEF.
- STU addr=0x0040, data=0x00AA, reg=2 -> mem_wr=1, mem_addr=0x0040, mem_wdata=0x00AA until done; then wb_data=0x0040, wb_reg=2, wb_wr_en=1.
- ST addr=0x0041 -> no mem_wr ever; next cycle wb_valid=1, wb_err=1, wb_wr_en=0.
- LD with memory silent, TIMEOUT=16 -> mem_rd drops after 16 ACCESS cycles; wb_valid=1, wb_err=1, wb_wr_en=0; next ADD accepted immediately.
- rst asserted on the 2nd ACCESS cycle, then a stray mem_done -> mem_rd=0 and all wb_* 0 after reset; no wb_valid; ex_ready=1.
